// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: bundles the upstream FIFO handshake and the serial-side
// outputs of fifo_uart_tx.
//   en          transmit enable (starts of new frames only)
//   fifo_empty  upstream FIFO empty flag
//   fifo_dout   upstream FIFO head word (first-word-fall-through)
//   fifo_deq    single-cycle pop strobe back to the FIFO
//   tx          serial line, idle high
//   busy        frame in progress
// master: the side that owns the FIFO and enable; slave: the transmitter.
interface fifo_uart_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_deq;
    logic             tx;
    logic             busy;

    modport master (
        output en,
        output fifo_empty,
        output fifo_dout,
        input  fifo_deq,
        input  tx,
        input  busy
    );

    modport slave (
        input  en,
        input  fifo_empty,
        input  fifo_dout,
        output fifo_deq,
        output tx,
        output busy
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a first-word-fall-through FIFO and sends each
// as a UART frame (1 start bit, WIDTH data bits LSB first, 1 stop bit, no
// parity), every bit lasting DIV clocks.
//   clk   system clock, rising edge
//   rst   synchronous active-high reset; aborts any frame in flight
//   bus   fifo_uart_tx_if.slave: en, fifo_empty, fifo_dout in;
//         fifo_deq (combinational pop strobe), tx, busy out
module fifo_uart_tx #(
    parameter int unsigned DIV   = 868,
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    fifo_uart_tx_if.slave bus
);
    localparam int unsigned BAUD_W = $clog2(DIV);
    localparam int unsigned BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q,  baud_d;
    logic [BIT_W-1:0]   bit_q,   bit_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               tx_q,    tx_d;
    logic               busy_q,  busy_d;

    logic               deq_c;
    logic               baud_tick_c;
    logic [WIDTH-1:0]   shift_next_c;

    // Pop only from IDLE; rst masks it so no word is lost during reset.
    assign deq_c        = (state_q == IDLE) & bus.en & ~bus.fifo_empty & ~rst;
    assign baud_tick_c  = (baud_q == BAUD_LAST);
    assign shift_next_c = shift_q >> 1;

    assign bus.fifo_deq = deq_c;
    assign bus.tx       = tx_q;
    assign bus.busy     = busy_q;

    // Next-state, counters and the registered line value for the next clock.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                bit_d  = '0;
                if (deq_c) begin
                    shift_d = bus.fifo_dout;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end

            START: begin
                baud_d = baud_tick_c ? '0 : baud_q + BAUD_W'(1);
                if (baud_tick_c) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end

            DATA: begin
                baud_d = baud_tick_c ? '0 : baud_q + BAUD_W'(1);
                if (baud_tick_c) begin
                    shift_d = shift_next_c;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                        bit_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        // Next LSB is presented on the line in the same edge
                        // that shifts it into position.
                        tx_d  = shift_next_c[0];
                    end
                end
            end

            STOP: begin
                baud_d = baud_tick_c ? '0 : baud_q + BAUD_W'(1);
                tx_d   = 1'b1;
                if (baud_tick_c) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                baud_d  = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: drives fifo_uart_tx (DIV=4, WIDTH=8) from a queue-based
// FIFO model. A frame-position reference model predicts tx/busy/fifo_deq
// every cycle; words the reference pops go into a scoreboard that a separate
// line monitor consumes by decoding UART frames from tx.
module tb_fifo_uart_tx;
    localparam int unsigned DIV   = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned FRAME = (WIDTH + 2) * DIV;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_uart_tx_if #(.WIDTH(WIDTH)) bus ();

    fifo_uart_tx #(.DIV(DIV), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] sb[$];

    int               ref_rem  = 0;
    logic [WIDTH-1:0] ref_word = '0;
    bit               scramble = 1'b0;

    int               mon_cnt    = 0;
    bit               mon_active = 1'b0;
    logic [WIDTH-1:0] mon_data   = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Expected line level from the position within the current frame.
    function automatic logic ref_tx();
        int p;
        int b;
        if (ref_rem == 0) return 1'b1;
        p = FRAME - ref_rem;
        b = p / DIV;
        if (b == 0) return 1'b0;
        if (b <= WIDTH) return ref_word[b-1];
        return 1'b1;
    endfunction

    task automatic drive_fifo();
        if (scramble && ref_rem > 0) begin
            bus.fifo_empty = 1'($urandom_range(0, 1));
            bus.fifo_dout  = WIDTH'($urandom);
        end else begin
            bus.fifo_empty = (fq.size() == 0);
            bus.fifo_dout  = (fq.size() > 0) ? fq[0] : '0;
        end
    endtask

    // One clock: check outputs, apply inputs, check pop, advance reference.
    task automatic step(input logic r, input logic e);
        logic exp_deq;
        @(negedge clk);
        chk("tx", 32'(bus.tx), 32'(ref_tx()));
        chk("busy", 32'(bus.busy), 32'(ref_rem > 0));
        rst    = r;
        bus.en = e;
        drive_fifo();
        #1;
        exp_deq = !r && e && (fq.size() > 0) && (ref_rem == 0);
        chk("fifo_deq", 32'(bus.fifo_deq), 32'(exp_deq));
        if (r) begin
            // Drop the aborted word unless the monitor already took it.
            if (ref_rem > int'(DIV - DIV / 2) && sb.size() > 0) void'(sb.pop_back());
            ref_rem = 0;
        end else if (ref_rem > 0) begin
            ref_rem--;
        end else if (exp_deq) begin
            ref_word = fq[0];
            sb.push_back(fq[0]);
            ref_rem = FRAME;
        end
        if (bus.fifo_deq === 1'b1 && fq.size() > 0) void'(fq.pop_front());
    endtask

    // Line monitor: decodes frames by mid-bit sampling, compares to scoreboard.
    initial begin
        forever begin
            int k;
            @(negedge clk);
            #2;
            if (rst === 1'b1) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (bus.tx === 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                end
            end else begin
                mon_cnt++;
                if (mon_cnt % DIV == DIV / 2) begin
                    k = mon_cnt / DIV;
                    if (k >= 1 && k <= WIDTH) begin
                        mon_data[k-1] = bus.tx;
                    end else if (k == WIDTH + 1) begin
                        chk("stop_bit", 32'(bus.tx), 32'd1);
                        if (sb.size() == 0) chk("frame_unexpected", 32'd1, 32'd0);
                        else chk("frame_data", 32'(mon_data), 32'(sb.pop_front()));
                        mon_active = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        logic r;
        logic e;
        int   n;
        rst            = 1'b1;
        bus.en         = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_dout  = '0;

        // Reset state, then a pending word with en=1 held off until release.
        repeat (3) step(1'b1, 1'b0);
        fq.push_back(8'h55);
        repeat (2) step(1'b1, 1'b1);
        repeat (50) step(1'b0, 1'b1);

        // Back-to-back frames.
        fq.push_back(8'hA3);
        fq.push_back(8'h0F);
        repeat (100) step(1'b0, 1'b1);

        // Empty FIFO, then disabled with data waiting.
        repeat (100) step(1'b0, 1'b1);
        fq.push_back(8'h3C);
        repeat (100) step(1'b0, 1'b0);
        fq.delete();

        // Enable dropped ten clocks into a frame.
        fq.push_back(8'hFF);
        fq.push_back(8'h12);
        repeat (11) step(1'b0, 1'b1);
        repeat (60) step(1'b0, 1'b0);
        fq.delete();

        // Reset during data bit 3 of 0x00; next word must follow intact.
        fq.push_back(8'h00);
        fq.push_back(8'h5A);
        repeat (18) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (60) step(1'b0, 1'b1);

        // FIFO outputs scrambled while a frame is in progress.
        scramble = 1'b1;
        fq.push_back(8'hC6);
        repeat (50) step(1'b0, 1'b1);
        scramble = 1'b0;

        // Random traffic, enable toggles and occasional resets.
        e = 1'b1;
        repeat (3000) begin
            if ($urandom_range(0, 49) == 0) e = ~e;
            if ($urandom_range(0, 19) == 0) fq.push_back(WIDTH'($urandom));
            r = ($urandom_range(0, 499) == 0);
            step(r, e);
        end

        // Drain whatever is left, bounded.
        n = 0;
        while ((fq.size() > 0 || ref_rem > 0) && n < 5000) begin
            step(1'b0, 1'b1);
            n++;
        end
        chk("drain_timeout", 32'(n < 5000), 32'd1);
        repeat (5) step(1'b0, 1'b1);
        chk("sb_leftover", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter DIV, default 868, clocks per UART bit (legal range 2..65535).
REQ-002 SHALL have parameter WIDTH, default 8, data bits per frame.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  transmit enable; gates start of new frames only.
REQ-006 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 SHALL have port fifo_dout  input  WIDTH  upstream FIFO head word; first-word-fall-through, valid while fifo_empty=0.
REQ-008 SHALL have port fifo_deq  output  1  single-cycle pop strobe to upstream FIFO.
REQ-009 SHALL have port tx  output  1  serial line, idle high.
REQ-010 SHALL have port busy  output  1  high while a frame is in progress.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP; busy = (state != IDLE).
REQ-012 SHALL drive fifo_deq combinationally = (state==IDLE) & en & !fifo_empty & !rst; never high in any other state.
REQ-013 SHALL, on the edge where fifo_deq=1, latch fifo_dout into a WIDTH-bit shift register, clear baud counter, enter START.
REQ-014 SHALL drive tx from a register: 1 in IDLE and STOP, 0 in START, shift-register LSB in DATA.
REQ-015 SHALL hold each bit (start, each data, stop) for exactly DIV clocks, counted by a $clog2(DIV)-bit baud counter 0..DIV-1, wrapping to 0 on each bit boundary.
REQ-016 SHALL transmit data LSB first; shift register shifts right one bit at each DATA bit boundary; bit counter counts 0..WIDTH-1.
REQ-017 SHALL transition START->DATA after DIV clocks, DATA->STOP after WIDTH bits, STOP->IDLE after DIV clocks; exactly one stop bit, no parity.
REQ-018 SHALL produce tx falling edge one clock after the fifo_deq cycle (latency 1).
REQ-019 SHALL, with FIFO non-empty and en=1 continuously, re-pop in the first IDLE cycle; frame-to-frame period = (WIDTH+2)*DIV+1 clocks (one extra idle-high clock).
REQ-020 SHALL, when en falls mid-frame, complete the current frame normally and then remain IDLE.
REQ-021 SHALL ignore fifo_dout and fifo_empty changes while busy; transmitted word is the latched value only.
REQ-022 SHALL, when fifo_empty=1 in IDLE, stay IDLE with tx=1 and fifo_deq=0 indefinitely (no underflow pop).

Reset
REQ-023 SHALL, while rst=1, force state IDLE, tx=1, busy=0, baud and bit counters 0, shift register 0; fifo_deq=0.
REQ-024 SHALL, on rst asserted mid-frame, abort frame: tx=1 from next clock, in-flight word discarded (not re-popped).
REQ-025 SHALL allow a new pop in the first clock after rst deasserts if en=1 and fifo_empty=0.

Verification (DIV=4, WIDTH=8)
REQ-026 SHALL verify single byte: fifo_dout=0x55, empty 1->0, en=1 -> one fifo_deq pulse; tx = 0,1,0,1,0,1,0,1,0,1 each 4 clocks, starting 1 clock after deq; busy high 40 clocks.
REQ-027 SHALL verify back-to-back: FIFO holds 0xA3,0x0F -> two deq pulses 41 clocks apart; decoded bytes 0xA3 then 0x0F; exactly 1 idle-high clock between stop and next start.
REQ-028 SHALL verify empty/disable: fifo_empty=1 or en=0 for 200 clocks -> tx=1, fifo_deq=0, busy=0 throughout.
REQ-029 SHALL verify en drop: en=0 at clock 10 of frame 0xFF -> frame completes (start 0, eight 1s, stop 1), no second deq though FIFO non-empty.
REQ-030 SHALL verify reset mid-frame: rst pulsed at DATA bit 3 of 0x00 -> tx=1, busy=0 next clock; after release next FIFO word popped and sent intact.
REQ-031 SHALL verify data stability: fifo_dout changed every clock during frame of 0xC6 -> line still carries 0xC6.
